// File: rtl/add64_pkg.sv
// Shared width constant and result record for the add64 issue/result path.
package add64_pkg;

  localparam int ADD_W = 64;

  typedef struct packed {
    logic [ADD_W-1:0] sum;
    logic             cout;
  } res_t;

endpackage

// File: rtl/add64_res_fifo.sv
// Result buffer between the external adder and the res_* handshake.
// Circular buffer with modulo-DEPTH pointers; caller guarantees no push when full.
module add64_res_fifo
  import add64_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  res_t i_push_data,
  input  logic i_pop,
  output logic o_valid,
  output res_t o_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  res_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_pop;

  assign o_valid = (r_cnt != '0);
  assign w_pop   = i_pop && o_valid;
  // Empty buffer presents zeros so reset leaves the result bus at 0.
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/add64_issue.sv
// Issues operand pairs to an external registered 64-bit adder and buffers results
// with credit flow control. Optional carry chaining: define ADD64_ISSUE_CHAIN_EN.
module add64_issue
  import add64_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADD_W-1:0] in_a,
  input  logic [ADD_W-1:0] in_b,
  input  logic             in_cin,
`ifdef ADD64_ISSUE_CHAIN_EN
  input  logic             in_chain,
`endif
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_cin,
  input  logic [ADD_W-1:0] add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ADD_W-1:0] res_sum,
  output logic             res_cout
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADD_LAT:0] r_vld;
  logic [CW-1:0]    r_outst;
  logic             r_run;
  logic             w_xfer;
  logic             w_pop;
  logic             w_push;
  logic             w_cin;
  logic             w_credit;
  res_t             w_push_data;
  res_t             w_head;

  // Credits come only from registered state; a pop is visible one cycle later.
  assign w_credit = r_run && (r_outst < CW'(DEPTH));

`ifdef ADD64_ISSUE_CHAIN_EN
  logic r_last_cout;

  // A chained op waits until its predecessor's carry has come back.
  assign in_ready = w_credit && !(in_valid && in_chain && (|r_vld));
  assign w_cin    = in_chain ? r_last_cout : in_cin;

  always_ff @(posedge clk) begin
    if (!rst)        r_last_cout <= 1'b0;
    else if (w_push) r_last_cout <= add_cout;
  end
`else
  assign in_ready = w_credit;
  assign w_cin    = in_cin;
`endif

  assign w_xfer      = in_valid && in_ready;
  assign w_pop       = res_valid && res_ready;
  assign w_push      = r_vld[ADD_LAT];
  assign w_push_data = '{sum: add_sum, cout: add_cout};

  always_ff @(posedge clk) begin
    if (!rst) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (w_xfer) begin
      add_a   <= in_a;
      add_b   <= in_b;
      add_cin <= w_cin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld   <= '0;
      r_outst <= '0;
      r_run   <= 1'b0;
    end else begin
      r_vld[0] <= w_xfer;
      for (int k = 1; k <= ADD_LAT; k++) r_vld[k] <= r_vld[k-1];
      r_outst <= r_outst + CW'(w_xfer) - CW'(w_pop);
      r_run   <= 1'b1;
    end
  end

  add64_res_fifo #(.DEPTH(DEPTH)) u_res_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_valid     (res_valid),
    .o_data      (w_head)
  );

  assign res_sum  = w_head.sum;
  assign res_cout = w_head.cout;

endmodule

// File: tb/tb_add64_issue.sv
// Scoreboard bench for add64_issue with a registered external adder fixture.
module tb_add64_issue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
`ifdef ADD64_ISSUE_CHAIN_EN
  logic        in_chain;
`endif
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_sum;
  logic        add_cout;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_sum;
  logic        res_cout;

  int checks = 0;
  int errors = 0;

  logic [64:0] q[$];
  logic        m_cout;
  logic        s_xfer, s_pop, s_valid, s_rdy, s_have;
  logic [64:0] s_res, s_exp;

  always #5 clk = ~clk;

  // External adder with one registered stage.
  always @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 65'(add_cin);

  add64_issue #(.DEPTH(DEPTH), .ADD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADD64_ISSUE_CHAIN_EN
    .in_chain  (in_chain),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout)
  );

  // Sample on the falling edge, update the scoreboard, then step past the next rising edge.
  task automatic tick();
    logic c;
    @(negedge clk);
    s_xfer  = rst && in_valid && in_ready;
    s_pop   = rst && res_valid && res_ready;
    s_valid = res_valid;
    s_rdy   = in_ready;
    s_res   = {res_cout, res_sum};
    s_have  = 1'b0;
    if (s_pop && q.size() > 0) begin
      s_exp  = q.pop_front();
      s_have = 1'b1;
    end
    if (s_xfer) begin
      c = in_cin;
`ifdef ADD64_ISSUE_CHAIN_EN
      if (in_chain) c = m_cout;
`endif
      q.push_back({1'b0, in_a} + {1'b0, in_b} + 65'(c));
      m_cout = q[q.size()-1][64];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    q.delete(); m_cout = 1'b0;
    @(posedge clk); #1;
    repeat (3) tick();
    checks++;
    if ({in_ready, res_valid, res_sum, res_cout, add_a, add_b, add_cin} !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%h cout=%b a=%h b=%h cin=%b, want all 0",
               in_ready, res_valid, res_sum, res_cout, add_a, add_b, add_cin);
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b want 1", s_rdy);
    end
  endtask

  task automatic test_carry();
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = '1; in_b = 64'd1; in_cin = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (!s_xfer || add_a !== '1 || add_b !== 64'd1 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL carry_issue: xfer=%b a=%h b=%h cin=%b want 1/ffff_ffff_ffff_ffff/1/0",
               s_xfer, add_a, add_b, add_cin);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s_valid !== (c == 2)) begin
        errors++;
        $display("FAIL carry_latency[%0d]: res_valid=%b want %b", c, s_valid, (c == 2));
      end
      if (s_pop) begin
        checks++;
        if (!s_have || s_res !== s_exp || s_res !== {1'b1, 64'd0}) begin
          errors++;
          $display("FAIL carry_result: got %h want %h", s_res, {1'b1, 64'd0});
        end
      end
    end
    checks++;
    if (add_a !== '1) begin
      errors++;
      $display("FAIL operand_hold: add_a=%h want all ones", add_a);
    end
  endtask

  task automatic test_back_to_back();
    int npop = 0, first = -1, last = -1, stalls = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_a = 64'(c); in_b = 64'(c); in_cin = 1'b0;
      tick();
      if (c < 8 && s_rdy !== 1'b1) stalls++;
      if (s_pop) begin
        checks++;
        if (!s_have || s_res !== s_exp || s_res !== 65'(2 * npop)) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h want %h", npop, s_res, 65'(2 * npop));
        end
        if (first < 0) first = c;
        last = c;
        npop++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_in_ready: %0d stalled cycles, want 0", stalls);
    end
    checks++;
    if (npop != 8 || last - first != 7) begin
      errors++;
      $display("FAIL b2b_throughput: pops=%0d span=%0d want 8/7", npop, last - first);
    end
  endtask

  task automatic test_full();
    int n_acc = 0, moved = 0;
    logic        seen = 1'b0;
    logic [64:0] head = '0;
    res_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = 64'(100 + n_acc); in_b = 64'(n_acc); in_cin = 1'b1;
      tick();
      if (s_xfer) n_acc++;
      if (s_valid) begin
        if (!seen) head = s_res;
        else if (s_res !== head) moved++;
        seen = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc != DEPTH || s_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_credits: accepted=%0d in_ready=%b want %0d/0", n_acc, s_rdy, DEPTH);
    end
    checks++;
    if (!seen || moved != 0 || head !== {1'b0, 64'd101}) begin
      errors++;
      $display("FAIL full_head_stable: head=%h moved=%0d want 65'h65/0", head, moved);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 2) begin
        checks++;
        if (s_rdy !== (c == 1)) begin
          errors++;
          $display("FAIL drain_ready[%0d]: in_ready=%b want %b", c, s_rdy, (c == 1));
        end
      end
      if (s_pop) begin
        checks++;
        if (!s_have || s_res !== s_exp) begin
          errors++;
          $display("FAIL drain_result: got %h want %h", s_res, s_exp);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_empty: %0d results missing, want 0", q.size());
    end
  endtask

  task automatic test_mid_reset();
    int ghosts = 0;
    res_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_a = 64'(5 + c); in_b = 64'(7); in_cin = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    q.delete(); m_cout = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || add_a !== '0 || add_b !== '0) begin
      errors++;
      $display("FAIL midreset_clear: vld=%b a=%h b=%h want 0/0/0", res_valid, add_a, add_b);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_valid) ghosts++;
      if (c == 1) begin
        checks++;
        if (s_rdy !== 1'b1) begin
          errors++;
          $display("FAIL midreset_ready: in_ready=%b want 1", s_rdy);
        end
      end
    end
    checks++;
    if (ghosts != 0) begin
      errors++;
      $display("FAIL midreset_ghost: %0d stale results, want 0", ghosts);
    end
  endtask

`ifdef ADD64_ISSUE_CHAIN_EN
  task automatic test_chain();
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = '1; in_b = 64'd1; in_cin = 1'b0; in_chain = 1'b0;
    tick();
    in_a = '0; in_b = '0; in_chain = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 3) begin
        checks++;
        if (s_rdy !== (c == 2)) begin
          errors++;
          $display("FAIL chain_hold[%0d]: in_ready=%b want %b", c, s_rdy, (c == 2));
        end
      end
      if (s_xfer) begin in_valid = 1'b0; in_chain = 1'b0; end
      if (s_pop) begin
        checks++;
        if (!s_have || s_res !== s_exp) begin
          errors++;
          $display("FAIL chain_result: got %h want %h", s_res, s_exp);
        end
      end
    end
    checks++;
    if (q.size() != 0 || {res_cout, res_sum} !== 65'd0 || m_cout !== 1'b0) begin
      errors++;
      $display("FAIL chain_done: left=%0d last_cout=%b want 0/0", q.size(), m_cout);
    end
  endtask
`endif

  task automatic test_random();
    int n_ops = 0, viol = 0, cyc = 0, bad = 0;
    while (n_ops < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      res_ready = ($urandom_range(0, 9) < 6);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      in_cin    = 1'($urandom_range(0, 1));
`ifdef ADD64_ISSUE_CHAIN_EN
      in_chain  = ($urandom_range(0, 3) == 0);
`endif
      tick();
      cyc++;
      if (s_xfer) n_ops++;
      if (q.size() > DEPTH) viol++;
      if (s_pop) begin
        checks++;
        if (!s_have || s_res !== s_exp) begin
          errors++;
          bad++;
          $display("FAIL random_result: got %h want %h", s_res, s_exp);
        end
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (s_pop) begin
        checks++;
        if (!s_have || s_res !== s_exp) begin
          errors++;
          $display("FAIL random_drain: got %h want %h", s_res, s_exp);
        end
      end
    end
    checks++;
    if (n_ops != 10000 || q.size() != 0 || viol != 0) begin
      errors++;
      $display("FAIL random_summary: ops=%0d left=%0d over_depth=%0d want 10000/0/0",
               n_ops, q.size(), viol);
    end
  endtask

  initial begin
`ifdef ADD64_ISSUE_CHAIN_EN
    in_chain = 1'b0;
`endif
    test_reset();
    test_carry();
    test_back_to_back();
    test_full();
    test_mid_reset();
`ifdef ADD64_ISSUE_CHAIN_EN
    test_chain();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
